// File: rtl/axis_fifo_pkg.sv
// Shared width helpers for the AXI4-Stream FIFO: pointer/count width and beat-record packing.
package axis_fifo_pkg;

   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int keep_w(input int data_width);
      return data_width / 8;
   endfunction

   // One stored beat is {tlast, tuser, tkeep, tdata}.
   function automatic int entry_w(input int data_width, input int user_width);
      return data_width + keep_w(data_width) + user_width + 1;
   endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat store: synchronous write, asynchronous read for first-word-fall-through.
module axis_fifo_ram #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 8
)(
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO with first-word-fall-through output and programmable almost-full.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward packet gating; default build is cut-through.
module axis_sync_fifo
   import axis_fifo_pkg::*;
#(
   parameter int FIFO_DEPTH       = 512,
   parameter int TDATA_WIDTH      = 512,
   parameter int TUSER_WIDTH      = 1,
   parameter int PROG_FULL_THRESH = FIFO_DEPTH - 8
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [TDATA_WIDTH-1:0]     S_AXIS_TDATA,
   input  logic [TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
   input  logic [TUSER_WIDTH-1:0]     S_AXIS_TUSER,
   input  logic                       S_AXIS_TLAST,
   input  logic                       S_AXIS_TVALID,
   output logic                       S_AXIS_TREADY,
   output logic [TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
   output logic [TUSER_WIDTH-1:0]     M_AXIS_TUSER,
   output logic                       M_AXIS_TLAST,
   output logic                       M_AXIS_TVALID,
   input  logic                       M_AXIS_TREADY,
   output logic [$clog2(FIFO_DEPTH):0] wr_data_count,
   output logic [$clog2(FIFO_DEPTH):0] rd_data_count,
   output logic                       prog_full,
   output logic                       overflow_sticky
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int PW      = ptr_width(FIFO_DEPTH);
   localparam int ENTRY_W = entry_w(TDATA_WIDTH, TUSER_WIDTH);

   logic [PW-1:0]      wr_ptr, rd_ptr, occupancy;
   logic               ready_en, full, empty, wr_fire, rd_fire;
   logic [ENTRY_W-1:0] wr_entry, rd_entry;

   // Status is derived purely from registered pointers, so neither handshake side sees the other combinationally.
   assign occupancy     = wr_ptr - rd_ptr;
   assign full          = (occupancy == PW'(FIFO_DEPTH));
   assign empty         = (wr_ptr == rd_ptr);
   assign S_AXIS_TREADY = ready_en && !full;
   assign wr_fire       = S_AXIS_TVALID && S_AXIS_TREADY;
   assign rd_fire       = M_AXIS_TVALID && M_AXIS_TREADY;
   assign wr_data_count = occupancy;
   assign prog_full     = (occupancy >= PW'(PROG_FULL_THRESH));

   assign wr_entry = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TKEEP, S_AXIS_TDATA};
   assign {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TKEEP, M_AXIS_TDATA} = rd_entry;

   axis_fifo_ram #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rd_entry)
   );

   // ready_en holds TREADY low while in reset and for the cycle of release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         ready_en        <= 1'b0;
         overflow_sticky <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
         if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
         if (S_AXIS_TVALID && full) overflow_sticky <= 1'b1;
      end
   end

`ifdef AXIS_FIFO_PACKET_MODE_EN
   logic [PW-1:0] pkt_cnt, last_ptr;
   logic          wr_last, rd_last;

   assign wr_last = wr_fire && S_AXIS_TLAST;
   assign rd_last = rd_fire && M_AXIS_TLAST;

   // last_ptr marks one past the newest stored TLAST, bounding what a reader may drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt  <= '0;
         last_ptr <= '0;
      end else begin
         if (wr_last && !rd_last)      pkt_cnt <= pkt_cnt + PW'(1);
         else if (!wr_last && rd_last) pkt_cnt <= pkt_cnt - PW'(1);
         if (wr_last) last_ptr <= wr_ptr + PW'(1);
      end
   end

   // A full FIFO with no complete packet is released anyway so oversize packets cannot deadlock.
   assign M_AXIS_TVALID = !empty && ((pkt_cnt != '0) || full);

   always_comb begin
      rd_data_count = '0;
      if (pkt_cnt != '0) rd_data_count = last_ptr - rd_ptr;
      else if (full)     rd_data_count = occupancy;
   end
`else
   assign M_AXIS_TVALID = !empty;
   assign rd_data_count = occupancy;
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Self-checking bench for axis_sync_fifo: queue-based reference model compared every cycle, plus pinned literals.
module tb_axis_sync_fifo;

   localparam int DEPTH  = 16;
   localparam int DW     = 32;
   localparam int KW     = DW / 8;
   localparam int UW     = 2;
   localparam int THRESH = 12;
   localparam int CW     = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic          last;
      logic [UW-1:0] user;
      logic [KW-1:0] keep;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic [KW-1:0] s_tkeep = '0;
   logic [UW-1:0] s_tuser = '0;
   logic          s_tlast = 1'b0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic [UW-1:0] m_tuser;
   logic          m_tlast;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic [CW-1:0] wr_count, rd_count;
   logic          prog_full, overflow_sticky;

   int checks = 0;
   int errors = 0;

   axis_sync_fifo #(
      .FIFO_DEPTH       (DEPTH),
      .TDATA_WIDTH      (DW),
      .TUSER_WIDTH      (UW),
      .PROG_FULL_THRESH (THRESH)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .S_AXIS_TDATA    (s_tdata),
      .S_AXIS_TKEEP    (s_tkeep),
      .S_AXIS_TUSER    (s_tuser),
      .S_AXIS_TLAST    (s_tlast),
      .S_AXIS_TVALID   (s_tvalid),
      .S_AXIS_TREADY   (s_tready),
      .M_AXIS_TDATA    (m_tdata),
      .M_AXIS_TKEEP    (m_tkeep),
      .M_AXIS_TUSER    (m_tuser),
      .M_AXIS_TLAST    (m_tlast),
      .M_AXIS_TVALID   (m_tvalid),
      .M_AXIS_TREADY   (m_tready),
      .wr_data_count   (wr_count),
      .rd_data_count   (rd_count),
      .prog_full       (prog_full),
      .overflow_sticky (overflow_sticky)
   );

   always #5 clk = ~clk;

   // Reference model: contents as a queue of beats plus the two sticky/enable flags.
   beat_t q[$];
   bit    m_ready_en = 1'b0;
   bit    m_overflow = 1'b0;

   function automatic bit modelFull();
      return q.size() == DEPTH;
   endfunction

   function automatic bit modelReady();
      return m_ready_en && !modelFull();
   endfunction

   function automatic int modelReadable();
`ifdef AXIS_FIFO_PACKET_MODE_EN
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].last) return i + 1;
      end
      return modelFull() ? q.size() : 0;
`else
      return q.size();
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_ready_en = 1'b0;
         m_overflow = 1'b0;
      end else begin
         bit wf, rf;
         wf = s_tvalid && modelReady();
         rf = m_tready && (modelReadable() != 0);
         if (s_tvalid && modelFull()) m_overflow = 1'b1;
         if (rf) void'(q.pop_front());
         if (wf) q.push_back(beat_t'{s_tlast, s_tuser, s_tkeep, s_tdata});
         m_ready_en = 1'b1;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      checkOutput("s_tready", s_tready, modelReady());
      checkOutput("m_tvalid", m_tvalid, modelReadable() != 0);
      checkOutput("wr_data_count", wr_count, q.size());
      checkOutput("rd_data_count", rd_count, modelReadable());
      checkOutput("prog_full", prog_full, q.size() >= THRESH);
      checkOutput("overflow_sticky", overflow_sticky, m_overflow);
      if (modelReadable() != 0) begin
         checkOutput("m_tdata", m_tdata, q[0].data);
         checkOutput("m_tkeep", m_tkeep, q[0].keep);
         checkOutput("m_tuser", m_tuser, q[0].user);
         checkOutput("m_tlast", m_tlast, q[0].last);
      end
   end

   function automatic beat_t randBeat(input bit last);
      beat_t b;
      b.data = $urandom;
      b.keep = KW'($urandom);
      b.user = UW'($urandom);
      b.last = last;
      return b;
   endfunction

   // Drive one cycle of inputs, then return just after the next falling edge.
   task automatic applyStimulus(input bit sv, input beat_t b, input bit mr);
      s_tvalid = sv;
      s_tdata  = b.data;
      s_tkeep  = b.keep;
      s_tuser  = b.user;
      s_tlast  = b.last;
      m_tready = mr;
      @(negedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, '0, 1'b0);
   endtask

   // Empties the FIFO; one closing TLAST beat guarantees packet mode releases any partial packet.
   task automatic drainFifo();
      bit sent = 1'b0;
      int n = 0;
      while ((!sent || q.size() != 0) && n < 100) begin
         bit fire;
         fire = !sent && modelReady();
         applyStimulus(!sent, randBeat(1'b1), 1'b1);
         if (fire) sent = 1'b1;
         n++;
      end
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("drain_done", wr_count, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      beat_t b;
      int sent;

      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      idleCycle();
      checkOutput("lit_reset_tready", s_tready, 1);
      checkOutput("lit_reset_count", wr_count, 0);
      checkOutput("lit_reset_tvalid", m_tvalid, 0);

      $display("[TB] fill to full and overflow");
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, randBeat(1'b0), 1'b0);
      applyStimulus(1'b1, randBeat(1'b0), 1'b0);
      checkOutput("lit_full_count", wr_count, 16);
      checkOutput("lit_full_tready", s_tready, 0);
      checkOutput("lit_overflow", overflow_sticky, 1);

      $display("[TB] full with both sides active");
      repeat (100) applyStimulus(1'b1, randBeat(1'b0), 1'b1);
      drainFifo();

      $display("[TB] prog_full threshold");
      for (int i = 0; i < 11; i++) applyStimulus(1'b1, randBeat(1'b1), 1'b0);
      checkOutput("lit_pf_11", prog_full, 0);
      checkOutput("lit_count_11", wr_count, 11);
      applyStimulus(1'b1, randBeat(1'b1), 1'b0);
      checkOutput("lit_pf_12", prog_full, 1);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("lit_pf_drop", prog_full, 0);
      checkOutput("lit_count_drop", wr_count, 11);
      drainFifo();

      $display("[TB] random traffic with wrap");
      repeat (400) begin
         applyStimulus($urandom_range(0, 9) < 7, randBeat($urandom_range(0, 3) == 0),
                       $urandom_range(0, 9) < 6);
      end
      drainFifo();

`ifdef AXIS_FIFO_PACKET_MODE_EN
      $display("[TB] packet gating");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, randBeat(1'b0), 1'b0);
      idleCycle();
      checkOutput("lit_pkt_gated", m_tvalid, 0);
      checkOutput("lit_pkt_rdcount0", rd_count, 0);
      applyStimulus(1'b1, randBeat(1'b1), 1'b0);
      checkOutput("lit_pkt_release", m_tvalid, 1);
      checkOutput("lit_pkt_rdcount5", rd_count, 5);
      drainFifo();

      sent = 0;
      for (int i = 0; i < 300 && sent < 20; i++) begin
         bit fire;
         fire = modelReady();
         applyStimulus(1'b1, randBeat(sent == 19), 1'b1);
         if (fire) sent++;
      end
      checkOutput("lit_pkt_oversize", sent, 20);
      drainFifo();
`endif

      $display("[TB] asynchronous reset mid-read");
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, randBeat(1'b1), 1'b0);
      applyStimulus(1'b0, '0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("lit_arst_tready", s_tready, 0);
      checkOutput("lit_arst_tvalid", m_tvalid, 0);
      checkOutput("lit_arst_wrcount", wr_count, 0);
      checkOutput("lit_arst_rdcount", rd_count, 0);
      checkOutput("lit_arst_progfull", prog_full, 0);
      checkOutput("lit_arst_overflow", overflow_sticky, 0);
      m_tready = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      idleCycle();
      b = randBeat(1'b1);
      applyStimulus(1'b1, b, 1'b0);
      checkOutput("lit_post_tvalid", m_tvalid, 1);
      checkOutput("lit_post_tdata", m_tdata, b.data);
      checkOutput("lit_post_count", wr_count, 1);
      drainFifo();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
